// File: rtl/itrx_aib_phy_pkg.sv
// Shared AIB PHY definitions: RX init sequencer state encoding and default training pattern.
package itrx_aib_phy_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitClk = 3'd1,
    StRel1    = 3'd2,
    StRel0    = 3'd3,
    StCheck   = 3'd4,
    StReady   = 3'd5,
    StFail    = 3'd6
  } rx_init_state_e;

  localparam logic [1:0] TrnPatDefault = 2'b10;

endpackage

// File: rtl/itrx_aib_phy_sync_2ff.sv
// Two-flop synchronizer for a single-bit asynchronous level, reset to 0.
module itrx_aib_phy_sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/itrx_aib_phy_rx_init_seq.sv
// RX buffer bring-up sequencer: staged idat1/idat0 reset release, then training-pattern check
// with bounded retries. All outputs come straight from flops.
module itrx_aib_phy_rx_init_seq
  import itrx_aib_phy_pkg::*;
#(
  parameter int unsigned CLK_WAIT_CYC = 16,
  parameter int unsigned SETTLE_CYC   = 4,
  parameter int unsigned MATCH_CNT    = 8,
  parameter int unsigned WINDOW_CYC   = 32,
  parameter int unsigned MAX_RETRY    = 3,
  parameter logic [1:0]  TRN_PAT      = TrnPatDefault
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_en,
  input  logic       rx_clk_ok,
  input  logic       ubump_rx_1q,
  input  logic       ubump_rx_0ql,
  output logic       rxd0_irstb,
  output logic       rxd1_irstb,
  output logic       rx_ready,
  output logic       rx_fail,
  output logic [2:0] state_dbg
);

  localparam int unsigned PhaseMax = (CLK_WAIT_CYC > SETTLE_CYC) ? CLK_WAIT_CYC : SETTLE_CYC;
  localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
  localparam int unsigned MatchW   = $clog2(MATCH_CNT + 1);
  localparam int unsigned WinW     = $clog2(WINDOW_CYC + 1);
  localparam int unsigned RetryW   = $clog2(MAX_RETRY + 1);

  rx_init_state_e    state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [MatchW-1:0] match_q, match_d;
  logic [WinW-1:0]   win_q, win_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              rxd0_q, rxd0_d, rxd1_q, rxd1_d, ready_q, ready_d, fail_q, fail_d;
  logic              clk_ok;
  logic              pat_ok;

  itrx_aib_phy_sync_2ff u_clk_ok_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx_clk_ok),
    .q    (clk_ok)
  );

  assign pat_ok = ({ubump_rx_1q, ubump_rx_0ql} == TRN_PAT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      phase_q <= '0;
      match_q <= '0;
      win_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      match_q <= match_d;
      win_q   <= win_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    match_d = match_q;
    win_d   = win_q;
    retry_d = retry_q;
    unique case (state_q)
      StIdle: begin
        if (rx_en && clk_ok) state_d = StWaitClk;
      end
      StWaitClk: begin
        if (phase_q >= PhaseW'(CLK_WAIT_CYC - 1)) begin
          state_d = StRel1;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StRel1: begin
        if (phase_q >= PhaseW'(SETTLE_CYC - 1)) begin
          state_d = StRel0;
          phase_d = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StRel0: begin
        if (phase_q >= PhaseW'(SETTLE_CYC - 1)) begin
          state_d = StCheck;
          phase_d = '0;
          match_d = '0;
          win_d   = '0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StCheck: begin
        if (!pat_ok) begin
          match_d = '0;
        end else if (match_q < MatchW'(MATCH_CNT)) begin
          match_d = match_q + 1'b1;
        end
        if (win_q < WinW'(WINDOW_CYC)) win_d = win_q + 1'b1;
        // A completed match takes precedence over a window expiring in the same cycle.
        if (match_q >= MatchW'(MATCH_CNT)) begin
          state_d = StReady;
        end else if (win_q >= WinW'(WINDOW_CYC - 1)) begin
          if (retry_q < RetryW'(MAX_RETRY)) retry_d = retry_q + 1'b1;
          phase_d = '0;
          state_d = (retry_d == RetryW'(MAX_RETRY)) ? StFail : StWaitClk;
        end
      end
      StReady: begin
        if (!clk_ok) state_d = StIdle;
      end
      StFail: begin
        state_d = StFail;
      end
      default: state_d = StIdle;
    endcase

    if (!clk_ok && (state_q inside {StWaitClk, StRel1, StRel0, StCheck})) state_d = StIdle;
    if (!rx_en) state_d = StIdle;

    // IDLE always holds cleared counters so every bring-up starts from zero.
    if (state_d == StIdle) begin
      phase_d = '0;
      match_d = '0;
      win_d   = '0;
      retry_d = '0;
    end
  end

  // Outputs decode the next state so the registered values line up with state_q.
  always_comb begin
    rxd1_d  = state_d inside {StRel1, StRel0, StCheck, StReady};
    rxd0_d  = state_d inside {StRel0, StCheck, StReady};
    ready_d = (state_d == StReady);
    fail_d  = (state_d == StFail);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxd0_q  <= 1'b0;
      rxd1_q  <= 1'b0;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      rxd0_q  <= rxd0_d;
      rxd1_q  <= rxd1_d;
      ready_q <= ready_d;
      fail_q  <= fail_d;
    end
  end

  assign rxd0_irstb = rxd0_q;
  assign rxd1_irstb = rxd1_q;
  assign rx_ready   = ready_q;
  assign rx_fail    = fail_q;
  assign state_dbg  = state_q;

endmodule
